// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one spi_master among NUM_REQ clients using
// round-robin arbitration. Each byte is sequenced as grant, start pulse,
// wait for done, response/ack, then a guard gap of GAP_CYCLES idle cycles.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transfer whose
// done does not arrive within TIMEOUT_CYC WAIT cycles (ack with err=1).
module spi_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      err,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        cs_sel,
    output logic                      m_start,
    output logic [DATA_W-1:0]         m_data_in,
    input  logic                      m_done,
    input  logic [DATA_W-1:0]         m_data_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES > 15 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("spi_req_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_gnt;
    logic [3:0]         gap_cnt;
    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               win_vld;
    logic               timeout_hit;

    // The client being acked this cycle must re-request next cycle to count
    assign elig = req & ~ack;

    // Round-robin search starting just after the last granted client
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_gnt) + i) % NUM_REQ);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == WAIT) && !m_done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // WAIT-cycle counter, cleared on every entry into WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state == START)
            to_cnt <= '0;
        else if (state == WAIT)
            to_cnt <= to_cnt + 1'b1;
    end

    // Abort flag accompanies the ack of a timed-out transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else
            err <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Transfer sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            last_gnt  <= IDX_W'(NUM_REQ - 1);
            gap_cnt   <= '0;
            ack       <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            cs_sel    <= '0;
            m_start   <= 1'b0;
            m_data_in <= '0;
        end else begin
            ack     <= '0;
            m_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        idx       <= win_idx;
                        last_gnt  <= win_idx;
                        m_data_in <= req_data[32'(win_idx)*DATA_W +: DATA_W];
                        cs_sel    <= NUM_REQ'(1) << win_idx;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    m_start <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (m_done || timeout_hit) begin
                        rsp_data <= m_done ? m_data_out : '0;
                        ack      <= NUM_REQ'(1) << idx;
                        cs_sel   <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= 4'(GAP_CYCLES);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed self-checking bench for spi_req_arbiter
// (NUM_REQ=4, DATA_W=8, GAP_CYCLES=2, TIMEOUT_CYC=64) with a simple
// spi_master model answering each start with (tx ^ mdl_xor) after mdl_dly cycles.
module tb_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [7:0]  rsp_data;
  logic        err;
  logic        busy;
  logic [3:0]  cs_sel;
  logic        m_start;
  logic [7:0]  m_data_in;
  logic        m_done;
  logic [7:0]  m_data_out;

  logic        mdl_en = 1'b0;
  int unsigned mdl_dly = 5;
  logic [7:0]  mdl_xor = '0;
  logic        mdl_done = 1'b0;
  logic [7:0]  mdl_data = '0;
  logic        stray_done = 1'b0;
  logic [7:0]  stray_data = '0;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  int unsigned w_n, w_starts, w_zeros;
  logic [3:0]  w_ack;
  logic [7:0]  w_rsp, w_tx;
  logic        w_err;

  logic [3:0]  rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0]  rr_rsp [5] = '{8'hEE, 8'hDD, 8'h5A, 8'hBB, 8'hEE};
  logic [7:0]  rr_tx  [5] = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h11};

  assign m_done     = mdl_done | stray_done;
  assign m_data_out = stray_done ? stray_data : mdl_data;

  spi_req_arbiter #(
    .NUM_REQ    (4),
    .DATA_W     (8),
    .GAP_CYCLES (2),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .rsp_data  (rsp_data),
    .err       (err),
    .busy      (busy),
    .cs_sel    (cs_sel),
    .m_start   (m_start),
    .m_data_in (m_data_in),
    .m_done    (m_done),
    .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  // spi_master model: done pulse mdl_dly cycles after the start pulse
  initial begin : master_model
    logic [7:0] tx;
    forever begin
      @(negedge clk);
      if (mdl_en && m_start) begin
        tx = m_data_in;
        repeat (mdl_dly) @(negedge clk);
        mdl_data = tx ^ mdl_xor;
        mdl_done = 1'b1;
        @(negedge clk);
        mdl_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Step until an ack appears (bounded); report latency, start pulses,
  // leading cs_sel=0 cycles and the tx byte seen at the start pulse
  task automatic wait_ack(input int unsigned limit,
                          output int unsigned n, output logic [3:0] a,
                          output logic [7:0] d, output logic e,
                          output int unsigned starts, output int unsigned zeros,
                          output logic [7:0] tx);
    logic lead;
    n = 0; a = '0; d = '0; e = 1'b0; starts = 0; zeros = 0; tx = '0;
    lead = 1'b1;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (lead && cs_sel == 4'b0000) zeros++;
      else lead = 1'b0;
      if (m_start) begin
        starts++;
        tx = m_data_in;
      end
      if (ack != 4'b0000) begin
        a = ack;
        d = rsp_data;
        e = err;
        break;
      end
    end
  endtask

  initial begin : stim
    // Reset state
    cyc(2);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_rsp", rsp_data, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cs", cs_sel, 4'b0000);
    chk("rst_start", m_start, 1'b0);
    chk("rst_din", m_data_in, 8'h00);
    rst = 1'b0;
    cyc(2);

    // Round robin with all four requesting
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    mdl_en = 1'b1; mdl_dly = 5; mdl_xor = 8'hFF;
    req = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
      chk("rr_ack", w_ack, rr_ack[k]);
      chk("rr_rsp", w_rsp, rr_rsp[k]);
      chk("rr_tx", w_tx, rr_tx[k]);
      chk("rr_starts", w_starts, 1);
      chk("rr_lat", w_n, (k == 0) ? 8 : 10);
      if (k > 0) chk("rr_gap", w_zeros, 2);
    end
    req = 4'b0000;
    cyc(3);

    // Wrap: last grant 3, then 0 and 3 together -> 0 first
    req = 4'b1000;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("wrap_ack3", w_ack, 4'b1000);
    req = 4'b1001;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("wrap_ack0", w_ack, 4'b0001);
    chk("wrap_rsp0", w_rsp, 8'hEE);
    req = 4'b1000;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("wrap_ack3b", w_ack, 4'b1000);
    chk("wrap_rsp3b", w_rsp, 8'hBB);
    req = 4'b0000;
    cyc(3);

    // Single transfer on client 2, slow master, tx latched at grant
    mdl_dly = 20; mdl_xor = 8'h99;
    req = 4'b0100;
    cyc(1);
    chk("s1_busy", busy, 1'b1);
    chk("s1_cs", cs_sel, 4'b0100);
    chk("s1_din", m_data_in, 8'hA5);
    chk("s1_start_early", m_start, 1'b0);
    req_data[23:16] = 8'h5A;
    cyc(1);
    chk("s1_start", m_start, 1'b1);
    cyc(1);
    chk("s1_start_end", m_start, 1'b0);
    chk("s1_din_hold", m_data_in, 8'hA5);
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("s1_lat", w_n, 20);
    chk("s1_ack", w_ack, 4'b0100);
    chk("s1_rsp", w_rsp, 8'h3C);
    chk("s1_err", w_err, 1'b0);
    chk("s1_extra_start", w_starts, 0);
    chk("s1_cs_off", cs_sel, 4'b0000);
    req = 4'b0000;
    req_data[23:16] = 8'hA5;
    cyc(1);
    chk("s1_gap_busy", busy, 1'b1);
    chk("s1_gap_ack", ack, 4'b0000);
    cyc(1);
    chk("s1_idle_busy", busy, 1'b0);
    chk("s1_rsp_hold", rsp_data, 8'h3C);

    // Stray done in IDLE
    stray_data = 8'h77;
    stray_done = 1'b1;
    cyc(1);
    stray_done = 1'b0;
    chk("s5_idle_ack", ack, 4'b0000);
    chk("s5_idle_rsp", rsp_data, 8'h3C);
    cyc(1);
    chk("s5_idle_busy", busy, 1'b0);

    // Stray done in GAP
    mdl_dly = 5; mdl_xor = 8'h00;
    req = 4'b0010;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("s5_ack1", w_ack, 4'b0010);
    chk("s5_rsp1", w_rsp, 8'h22);
    req = 4'b0000;
    stray_done = 1'b1;
    cyc(1);
    stray_done = 1'b0;
    chk("s5_gap_ack", ack, 4'b0000);
    chk("s5_gap_rsp", rsp_data, 8'h22);
    cyc(3);

    // req dropped during WAIT still completes
    mdl_dly = 8;
    req = 4'b0001;
    cyc(3);
    chk("s5_wait_cs", cs_sel, 4'b0001);
    req = 4'b0000;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("s5_drop_lat", w_n, 8);
    chk("s5_drop_ack", w_ack, 4'b0001);
    chk("s5_drop_rsp", w_rsp, 8'h11);
    cyc(3);

    // Reset in the middle of WAIT
    mdl_en = 1'b0;
    req = 4'b0001;
    cyc(2);
    chk("s4_start", m_start, 1'b1);
    cyc(10);
    rst = 1'b1;
    #1;
    chk("s4_cs", cs_sel, 4'b0000);
    chk("s4_busy", busy, 1'b0);
    chk("s4_ack", ack, 4'b0000);
    chk("s4_rsp", rsp_data, 8'h00);
    chk("s4_din", m_data_in, 8'h00);
    cyc(1);
    rst = 1'b0;
    mdl_en = 1'b1; mdl_dly = 5; mdl_xor = 8'h00;
    req = 4'b0011;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("s4_lat", w_n, 8);
    chk("s4_prio_ack", w_ack, 4'b0001);
    chk("s4_prio_rsp", w_rsp, 8'h11);
    req = 4'b0010;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("s4_c1_ack", w_ack, 4'b0010);
    chk("s4_c1_rsp", w_rsp, 8'h22);
    req = 4'b0000;
    cyc(3);

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout abort, then normal service of the next client
    mdl_en = 1'b0;
    req = 4'b0100;
    wait_ack(200, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("to_lat", w_n, 66);
    chk("to_ack", w_ack, 4'b0100);
    chk("to_err", w_err, 1'b1);
    chk("to_rsp", w_rsp, 8'h00);
    req = 4'b1000;
    mdl_en = 1'b1; mdl_dly = 5; mdl_xor = 8'hFF;
    wait_ack(100, w_n, w_ack, w_rsp, w_err, w_starts, w_zeros, w_tx);
    chk("to_next_lat", w_n, 10);
    chk("to_next_ack", w_ack, 4'b1000);
    chk("to_next_err", w_err, 1'b0);
    chk("to_next_rsp", w_rsp, 8'hBB);
    req = 4'b0000;
    cyc(3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
